// File: rtl/seg7_scan_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_ctrl_if
//  Description : Host write channel and display-pin bundle for the
//                seven-segment scan controller.
//                The master side is the host and board pins. The slave side
//                is the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_ctrl_if;
    logic        en;
    logic        wr_en;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic [7:0]  wr_mask;
    logic [7:0]  wr_dp;
    logic [7:0]  sel_seg;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    modport master (
        output en, wr_en, wr_data, wr_mask, wr_dp,
        input  wr_ready, sel_seg, seg, dp, frame_start
    );

    modport slave (
        input  en, wr_en, wr_data, wr_mask, wr_dp,
        output wr_ready, sel_seg, seg, dp, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_ctrl
//  Description : Time-multiplexed scan controller for an 8-digit,
//                common-anode seven-segment display. The host writes a frame
//                through a ready/valid handshake. The frame is held in a
//                pending buffer and committed to the shadow registers only at
//                a frame boundary, so no frame mixes old and new data.
//  Options     : SEG7_LZ_BLANK_EN - when defined, leading-zero suppression
//                blanks digits k>0 whose nibbles k..7 are all zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
    parameter int SCAN_DIV = 100000,
    parameter int DIV_W    = 17
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    seg7_scan_ctrl_if.slave    bus
);

    localparam logic [DIV_W-1:0] C_DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] C_DIV_ONE = DIV_W'(1);

    // Scan state
    logic [DIV_W-1:0] div_q,   div_d;
    logic [2:0]       idx_q,   idx_d;
    logic [7:0]       sel_q,   sel_d;
    logic [6:0]       seg_q,   seg_d;
    logic             dp_q,    dp_d;
    logic             fs_q,    fs_d;

    // Write path and frame storage
    logic             rdy_q,   rdy_d;
    logic             pfull_q, pfull_d;
    logic [31:0]      pdata_q, pdata_d;
    logic [7:0]       pmask_q, pmask_d;
    logic [7:0]       pdp_q,   pdp_d;
    logic [31:0]      sdata_q, sdata_d;
    logic [7:0]       smask_q, smask_d;
    logic [7:0]       sdp_q,   sdp_d;

    logic             w_tick;
    logic             w_wrap;
    logic             w_commit;
    logic             w_xfer;
    logic [2:0]       w_idx_next;
    logic [31:0]      w_src_data;
    logic [7:0]       w_src_mask;
    logic [7:0]       w_src_dp;
    logic [3:0]       w_nib;
    logic             w_blank;

    // Hex digit to active-low segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_tick     = bus.en && (div_q == C_DIV_MAX);
    assign w_idx_next = idx_q + 3'd1;
    assign w_wrap     = w_tick && (idx_q == 3'd7);
    // With the display stopped, no frame is in flight, so commit at once
    assign w_commit   = pfull_q && (bus.en ? w_wrap : 1'b1);
    assign w_xfer     = bus.wr_en && rdy_q;

    // On a commit edge, digit 0 must already show the new frame
    assign w_src_data = w_commit ? pdata_q : sdata_q;
    assign w_src_mask = w_commit ? pmask_q : smask_q;
    assign w_src_dp   = w_commit ? pdp_q   : sdp_q;
    assign w_nib      = w_src_data[{w_idx_next, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
    assign w_blank = (w_idx_next != 3'd0) &&
                     ((w_src_data >> {w_idx_next, 2'b00}) == 32'd0);
`else
    assign w_blank = 1'b0;
`endif

    // Next-state logic for the scan sequencer, handshake and frame buffers
    always_comb begin
        div_d   = div_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        fs_d    = 1'b0;
        rdy_d   = ~pfull_q;
        pfull_d = pfull_q;
        pdata_d = pdata_q;
        pmask_d = pmask_q;
        pdp_d   = pdp_q;
        sdata_d = sdata_q;
        smask_d = smask_q;
        sdp_d   = sdp_q;

        if (!bus.en) begin
            div_d = '0;
            idx_d = 3'd7;
            sel_d = 8'hFF;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end else if (w_tick) begin
            div_d = '0;
            idx_d = w_idx_next;
            sel_d = ~(8'b1 << w_idx_next);
            seg_d = (w_src_mask[w_idx_next] && !w_blank) ? f_decode(w_nib) : 7'h7F;
            dp_d  = ~(w_src_dp[w_idx_next] & w_src_mask[w_idx_next]);
            fs_d  = w_commit;
        end else begin
            div_d = div_q + C_DIV_ONE;
        end

        if (w_commit) begin
            sdata_d = pdata_q;
            smask_d = pmask_q;
            sdp_d   = pdp_q;
            pfull_d = 1'b0;
        end

        // A transfer needs wr_ready=1, which implies the buffer is empty
        if (w_xfer) begin
            pdata_d = bus.wr_data;
            pmask_d = bus.wr_mask;
            pdp_d   = bus.wr_dp;
            pfull_d = 1'b1;
            rdy_d   = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q   <= '0;
            idx_q   <= 3'd7;
            sel_q   <= 8'hFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            fs_q    <= 1'b0;
            rdy_q   <= 1'b1;
            pfull_q <= 1'b0;
            pdata_q <= '0;
            pmask_q <= '0;
            pdp_q   <= '0;
            sdata_q <= '0;
            smask_q <= '0;
            sdp_q   <= '0;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fs_q    <= fs_d;
            rdy_q   <= rdy_d;
            pfull_q <= pfull_d;
            pdata_q <= pdata_d;
            pmask_q <= pmask_d;
            pdp_q   <= pdp_d;
            sdata_q <= sdata_d;
            smask_q <= smask_d;
            sdp_q   <= sdp_d;
        end
    end

    assign bus.sel_seg     = sel_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = fs_q;
    assign bus.wr_ready    = rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_ctrl
//  Description : Scoreboard testbench for seg7_scan_ctrl with SCAN_DIV=4.
//                Each expected digit slot is queued when its frame is written.
//                The monitor pops the next expected slot on every change of
//                sel_seg.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int SCAN_DIV = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_ctrl_if u_if ();

    seg7_scan_ctrl #(
        .SCAN_DIV (SCAN_DIV),
        .DIV_W    (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    typedef struct packed {
        logic [7:0] sel;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass   = 0;
    int   n_checks = 0;
    bit   done     = 1'b0;

    logic [6:0] c_dec [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit f_blank(input logic [31:0] d, input int k);
`ifdef SEG7_LZ_BLANK_EN
        return (k > 0) && ((d >> (4 * k)) == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_frame(input logic [31:0] d, input logic [7:0] m, input logic [7:0] p,
                              input bit fs, input int first, input int last);
        exp_t e;
        for (int k = first; k <= last; k++) begin
            e.sel = ~(8'b1 << k);
            e.seg = (m[k] && !f_blank(d, k)) ? c_dec[d[4*k +: 4]] : 7'h7F;
            e.dp  = ~(p[k] & m[k]);
            e.fs  = fs && (k == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_dark();
        exp_t e;
        e.sel = 8'hFF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.fs  = 1'b0;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge
    task automatic do_write(input logic [31:0] d, input logic [7:0] m, input logic [7:0] p);
        chk("wr_ready_idle", u_if.wr_ready, 1);
        u_if.wr_en   = 1'b1;
        u_if.wr_data = d;
        u_if.wr_mask = m;
        u_if.wr_dp   = p;
        @(posedge clk);
        #1 u_if.wr_en = 1'b0;
        @(negedge clk);
        chk("wr_ready_busy", u_if.wr_ready, 0);
    endtask

    task automatic wait_sel(input logic [7:0] v, input string tag);
        int n = 0;
        while (u_if.sel_seg !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, u_if.sel_seg, v);
    endtask

    task automatic wait_fs(input string tag);
        int n = 0;
        while (u_if.frame_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, u_if.frame_start, 1);
    endtask

    // Monitor: every change of the digit select is one scoreboard event
    logic [7:0] prev_sel = 8'hFF;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_sel = 8'hFF;
        end else if (!done && u_if.sel_seg !== prev_sel) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_slot", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("slot_sel", u_if.sel_seg, e.sel);
                chk("slot_seg", u_if.seg, e.seg);
                chk("slot_dp", u_if.dp, e.dp);
                chk("slot_fs", u_if.frame_start, e.fs);
            end
            prev_sel = u_if.sel_seg;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        u_if.en      = 1'b0;
        u_if.wr_en   = 1'b0;
        u_if.wr_data = '0;
        u_if.wr_mask = '0;
        u_if.wr_dp   = '0;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sel", u_if.sel_seg, 8'hFF);
        chk("rst_seg", u_if.seg, 7'h7F);
        chk("rst_dp", u_if.dp, 1);
        chk("rst_ready", u_if.wr_ready, 1);
        chk("rst_fs", u_if.frame_start, 0);
        rst_n = 1'b1;

        // First frame, committed at the first wrap
        push_frame(32'h76543210, 8'hFF, 8'h01, 1'b1, 0, 7);
        u_if.en = 1'b1;
        do_write(32'h76543210, 8'hFF, 8'h01);

        // New write while digit 3 is lit; a second request while busy is dropped
        wait_sel(8'hF7, "t3_digit3");
        push_frame(32'hFFFFFFFF, 8'hFF, 8'h00, 1'b1, 0, 7);
        do_write(32'hFFFFFFFF, 8'hFF, 8'h00);
        u_if.wr_en   = 1'b1;
        u_if.wr_data = 32'h11111111;
        u_if.wr_mask = 8'h00;
        u_if.wr_dp   = 8'hFF;
        @(posedge clk);
        #1 u_if.wr_en = 1'b0;
        @(negedge clk);
        chk("t3_ignored_ready", u_if.wr_ready, 0);
        wait_fs("t3_fs");
        chk("t3_ready_at_fs", u_if.wr_ready, 0);
        @(negedge clk);
        chk("t3_ready_back", u_if.wr_ready, 1);

        // Partial mask
        push_frame(32'h89AB0123, 8'h0F, 8'hF2, 1'b1, 0, 5);
        do_write(32'h89AB0123, 8'h0F, 8'hF2);
        wait_fs("t4_fs");
        wait_sel(8'hDF, "t4_digit5");

        // Disable mid-frame, then re-enable with retained data
        push_dark();
        u_if.en = 1'b0;
        @(negedge clk);
        chk("t5_dark_sel", u_if.sel_seg, 8'hFF);
        chk("t5_dark_seg", u_if.seg, 7'h7F);
        chk("t5_dark_dp", u_if.dp, 1);
        push_frame(32'h89AB0123, 8'h0F, 8'hF2, 1'b0, 0, 7);
        u_if.en = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_lat3", u_if.sel_seg, 8'hFF);
        @(negedge clk);
        chk("t5_lat4", u_if.sel_seg, 8'hFE);

        // Leading-zero frame
        push_frame(32'h00000A05, 8'hFF, 8'h00, 1'b1, 0, 7);
        do_write(32'h00000A05, 8'hFF, 8'h00);
        wait_fs("t6_fs");
        wait_sel(8'h7F, "t6_digit7");

        // Write with the display disabled commits immediately, without frame_start
        push_dark();
        u_if.en = 1'b0;
        @(negedge clk);
        chk("t7_dark_sel", u_if.sel_seg, 8'hFF);
        do_write(32'h12345678, 8'h01, 8'h01);
        @(negedge clk);
        chk("t7_ready_commit", u_if.wr_ready, 0);
        chk("t7_fs_none", u_if.frame_start, 0);
        @(negedge clk);
        chk("t7_ready_back", u_if.wr_ready, 1);
        push_frame(32'h12345678, 8'h01, 8'h01, 1'b0, 0, 0);
        u_if.en = 1'b1;

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("sb_drain", exp_q.size(), 0);
        done = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
